// File: rtl/rca_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// rca_serial_add_ctrl
//
// Purpose
//   Adds or subtracts two WIDTH-bit operands by time-sharing one 4-bit
//   ripple-carry adder (rca_4). One nibble is processed per cycle, LSB
//   first. The carry between nibbles is kept in a register. This costs
//   latency but saves area compared with a full-width adder.
//   The block sits between an operand producer and a result consumer.
//   Both sides use a valid/ready handshake.
//
// Parameters
//   WIDTH   operand/result width; must be a multiple of 4 and >= 8
//   NIB     (derived) number of nibble passes per operation = WIDTH/4
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      a, b, cin, sub are valid
//   in_ready   out  1      block can accept an operation (IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in for add; ignored when sub=1
//   sub        in   1      1: A - B (A + ~B + 1), 0: A + B + cin
//   out_valid  out  1      sum/cout/ovf are valid (DONE)
//   out_ready  in   1      consumer accepts the result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//   ovf        out  1      two's-complement signed overflow
//   busy       out  1      high while nibble passes are running (RUN)
//
// Timing
//   A handshake at edge T raises out_valid at edge T+NIB.
//   When out_ready is held high, one operation completes every NIB+2 cycles.
// -----------------------------------------------------------------------------

// 4-bit ripple-carry adder: the only arithmetic in the design.
//   a, b   in   4   addends
//   cin    in   1   carry-in
//   s      out  4   sum
//   cout   out  1   carry-out of bit 3
module rca_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic ripple;

  // NOTE: every signal written in an always_comb block is given a value
  //       at the top. A path that leaves a signal unassigned would infer a latch.
  always_comb begin
    s      = '0;
    ripple = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ ripple;
      ripple = (a[i] & b[i]) | (ripple & (a[i] ^ b[i]));
    end
    cout = ripple;
  end

endmodule

module rca_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MSB   = WIDTH - 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q,     a_d;      // latched operand A
  logic [WIDTH-1:0] b_q,     b_d;      // latched B, already inverted for sub
  logic             carry_q, carry_d;  // carry between nibble passes
  logic [IDX_W-1:0] idx_q,   idx_d;    // nibble currently being added
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  // Bit offset of the current nibble. Concatenation keeps the width exact.
  logic [IDX_W+1:0] nib_lsb;
  logic [3:0]       rca_sum;
  logic             rca_cout;

  assign nib_lsb = {idx_q, 2'b00};

  rca_4 u_rca_4 (
    .a    (a_q[nib_lsb +: 4]),
    .b    (b_q[nib_lsb +: 4]),
    .cin  (carry_q),
    .s    (rca_sum),
    .cout (rca_cout)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is done as A + ~B + 1. The +1 enters as the
          // first-pass carry, so the adder itself never knows about sub.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sum_d[nib_lsb +: 4] = rca_sum;
        carry_d             = rca_cout;
        if (idx_q == IDX_LAST) begin
          // The overflow check uses the live adder output for the top nibble.
          // sum_q does not hold that nibble yet.
          cout_d  = rca_cout;
          ovf_d   = (a_q[MSB] == b_q[MSB]) && (rca_sum[3] != a_q[MSB]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  //       then update together from the values held before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // The handshake and status outputs decode the state directly.
  // They therefore take their reset values on the same edge as the state.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rca_serial_add_ctrl
//
// Directed bench for rca_serial_add_ctrl with WIDTH=16.
// A table of hand-computed vectors is applied in a loop.
// Hand-written sequences then cover the following:
//   - holding the result while out_ready is low
//   - back-to-back throughput
//   - a reset asserted in the middle of an operation
// -----------------------------------------------------------------------------
module tb_rca_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;

  rca_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle 1 ns after the edge.
  // All driving and sampling happen at that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one operation and check latency and results.
  // Then hold out_ready low for 'hold' cycles before consuming the result.
  task automatic run_op(input string tag, input vec_t v, input int hold);
    int lat;
    logic [15:0] held_sum;
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    tick();                       // handshake edge T
    in_valid = 1'b0;
    a   = 16'($urandom);          // inputs may change freely after accept
    b   = 16'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(NIB));
    check({tag, " sum"},  32'(sum),  32'(v.exp_sum));
    check({tag, " cout"}, 32'(cout), 32'(v.exp_cout));
    check({tag, " ovf"},  32'(ovf),  32'(v.exp_ovf));
    held_sum = sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;            // must be ignored while DONE
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      check($sformatf("%s hold%0d sum", tag, i),       32'(sum),       32'(held_sum));
      check($sformatf("%s hold%0d out_valid", tag, i), 32'(out_valid), 32'd1);
      check($sformatf("%s hold%0d in_ready", tag, i),  32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid after consume"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after consume"},  32'(in_ready),  32'd1);
  endtask

  vec_t vecs [12];

  initial begin
    //          a        b        cin   sub   sum      cout  ovf
    vecs[0]  = '{16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5]  = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[6]  = '{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1, 1'b0};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0};
    vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[11] = '{16'h8001, 16'hFFFF, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset sum",       32'(sum),       32'd0);
    check("reset cout",      32'(cout),      32'd0);
    check("reset ovf",       32'(ovf),       32'd0);
    rst = 1'b0;
    tick();

    // ---- vector table ----
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i], 0);
    end

    // ---- result held with out_ready low for 10 cycles ----
    run_op("hold 7FFF+1", vecs[4], 10);

    // ---- back-to-back: in_valid held high, out_ready high ----
    begin
      logic [15:0] ops_a   [4];
      logic [15:0] ops_b   [4];
      int          acc_cyc [4];
      int n_acc, n_res, cyc;
      logic        acc_now;
      logic [16:0] exp_full;
      for (int i = 0; i < 4; i++) begin
        ops_a[i] = 16'(16'h1111 * (i + 1));
        ops_b[i] = 16'(16'h0101 + i);
      end
      n_acc = 0; n_res = 0; cyc = 0;
      out_ready = 1'b1;
      a = ops_a[0]; b = ops_b[0]; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      while (n_res < 4 && cyc < 60) begin
        acc_now = in_valid && in_ready;
        if (out_valid) begin
          exp_full = {1'b0, ops_a[n_res]} + {1'b0, ops_b[n_res]};
          check($sformatf("b2b res%0d sum", n_res),  32'(sum),  32'(exp_full[15:0]));
          check($sformatf("b2b res%0d cout", n_res), 32'(cout), 32'(exp_full[16]));
          n_res++;
        end
        tick();
        cyc++;
        if (acc_now) begin
          acc_cyc[n_acc] = cyc;
          n_acc++;
          if (n_acc < 4) begin
            a = ops_a[n_acc];
            b = ops_b[n_acc];
          end else begin
            in_valid = 1'b0;
          end
        end
      end
      check("b2b accepted", 32'(n_acc), 32'd4);
      check("b2b results",  32'(n_res), 32'd4);
      for (int i = 1; i < 4; i++) begin
        if (i < n_acc) begin
          check($sformatf("b2b interval%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(NIB + 2));
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
    end

    // ---- reset in the second RUN cycle ----
    check("midrst in_ready before", 32'(in_ready), 32'd1);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();                       // accept; first RUN cycle
    in_valid = 1'b0;
    check("midrst busy run1", 32'(busy), 32'd1);
    tick();                       // second RUN cycle
    check("midrst busy run2", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst in_ready",  32'(in_ready),  32'd1);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst busy",      32'(busy),      32'd0);
    check("midrst sum",       32'(sum),       32'd0);
    run_op("after midrst", vecs[0], 0);
    run_op("after midrst2", vecs[3], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
